pid_channel_scheduler: RTL and testbench



---
 rtl/pid_channel_scheduler_pkg.sv | 33 +++
 rtl/pid_channel_scheduler_if.sv | 25 ++
 rtl/pid_channel_scheduler_tick_gen.sv | 32 +++
 rtl/pid_channel_scheduler.sv | 151 +++++++++++++++
 tb/tb_pid_channel_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pid_channel_scheduler_pkg.sv
// Shared definitions for the PID channel scheduler, PID engine and PWM output stage:
// FSM encoding, default widths and the symmetric command clamp.
package pid_channel_scheduler_pkg;

  localparam int CHN_WIDTH_DEF  = 3;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int RPM_MAX_DEF    = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_SELECT,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_FORWARD
  } sched_state_t;

  // Symmetric signed clamp to [-lim, +lim]; callers sign-extend into 32 bits first.
  function automatic logic signed [31:0] clamp_s32(
    input logic signed [31:0] v,
    input logic signed [31:0] lim
  );
    logic signed [31:0] r;
    r = v;
    if (v > lim) begin
      r = lim;
    end else if (v < -lim) begin
      r = -lim;
    end
    return r;
  endfunction

endpackage

// File: rtl/pid_channel_scheduler_if.sv
// PID engine start/done handshake plus the time-multiplexed command stream to the PWM stage.
interface pid_channel_scheduler_if #(
  parameter int CHN_WIDTH  = 3,
  parameter int DATA_WIDTH = 16
);

  logic                         pid_start;
  logic [CHN_WIDTH-1:0]         pid_chn;
  logic                         pid_done;
  logic signed [DATA_WIDTH-1:0] pid_u_data;
  logic                         u_valid_o;
  logic [CHN_WIDTH-1:0]         u_chn_o;
  logic signed [DATA_WIDTH-1:0] u_data_o;

  modport master (
    output pid_start, pid_chn, u_valid_o, u_chn_o, u_data_o,
    input  pid_done, pid_u_data
  );

  modport slave (
    input  pid_start, pid_chn, u_valid_o, u_chn_o, u_data_o,
    output pid_done, pid_u_data
  );

endinterface

// File: rtl/pid_channel_scheduler_tick_gen.sv
// Sample-rate divider: one-cycle tick every DIV+1 enabled cycles, counter parked at 0 when disabled.
module sample_tick_gen #(
  parameter int DIV = 26999
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (DIV > 0) ? $clog2(DIV + 1) : 1;

  logic [CNT_W-1:0] cnt;

  // Tick is registered so the first one lands DIV+1 cycles after enable is first sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!enable) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CNT_W'(DIV)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CNT_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/pid_channel_scheduler.sv
// Runs the shared PID engine over every channel once per sample tick, clamps and forwards each
// result, and tracks engine timeouts, sample overruns and the per-channel stop vector.
module pid_channel_scheduler
  import pid_channel_scheduler_pkg::*;
#(
  parameter int NUM_CHN     = 4,
  parameter int CHN_WIDTH   = CHN_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int RPM_MAX     = RPM_MAX_DEF,
  parameter int CLK_FREQ    = 27_000_000,
  parameter int SAMPLE_FREQ = 1_000,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [NUM_CHN-1:0]     stop_req,
  input  logic                   err_clr,
  pid_channel_scheduler_if.master bus,
  output logic [NUM_CHN-1:0]     stop,
  output logic [NUM_CHN-1:0]     timeout_err,
  output logic                   overrun
);

  localparam int SAMPLE_DIV = CLK_FREQ / SAMPLE_FREQ - 1;
  localparam int TMO_W      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CHN_WIDTH-1:0] LAST_CHN = CHN_WIDTH'(NUM_CHN - 1);

  sched_state_t         state;
  logic [CHN_WIDTH-1:0] chan;
  logic [TMO_W-1:0]     tmo_cnt;
  logic [NUM_CHN-1:0]   stop_q;
  logic [NUM_CHN-1:0]   chan_mask;
  logic                 chan_stopped;
  logic                 tick;

  function automatic logic signed [DATA_WIDTH-1:0] sat_cmd(
    input logic signed [DATA_WIDTH-1:0] v
  );
    logic signed [31:0] wide;
    wide = {{(32 - DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
    return DATA_WIDTH'(clamp_s32(wide, RPM_MAX));
  endfunction

  sample_tick_gen #(
    .DIV (SAMPLE_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  assign stop         = stop_q | timeout_err;
  assign chan_mask    = NUM_CHN'(1) << chan;
  assign chan_stopped = |(stop & chan_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      chan          <= '0;
      tmo_cnt       <= '0;
      stop_q        <= '0;
      timeout_err   <= '0;
      overrun       <= 1'b0;
      bus.pid_start <= 1'b0;
      bus.pid_chn   <= '0;
      bus.u_valid_o <= 1'b0;
      bus.u_chn_o   <= '0;
      bus.u_data_o  <= '0;
    end else begin
      stop_q        <= stop_req;
      bus.pid_start <= 1'b0;
      bus.u_valid_o <= 1'b0;

      // Clears are written first so any set later in this block takes priority.
      if (err_clr) begin
        timeout_err <= '0;
        overrun     <= 1'b0;
      end
      if (tick && (state != ST_WAIT_TICK)) begin
        overrun <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (enable) begin
            state <= ST_WAIT_TICK;
          end
        end

        ST_WAIT_TICK: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (tick) begin
            chan  <= '0;
            state <= ST_SELECT;
          end
        end

        ST_SELECT: begin
          if (chan_stopped) begin
            bus.u_valid_o <= 1'b1;
            bus.u_chn_o   <= chan;
            bus.u_data_o  <= '0;
            state         <= ST_FORWARD;
          end else begin
            bus.pid_start <= 1'b1;
            bus.pid_chn   <= chan;
            state         <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          tmo_cnt <= TMO_W'(TIMEOUT_CYC);
          state   <= ST_WAIT_DONE;
        end

        // A done on the final (count 0) cycle still beats the timeout.
        ST_WAIT_DONE: begin
          if (bus.pid_done) begin
            bus.u_valid_o <= 1'b1;
            bus.u_chn_o   <= chan;
            bus.u_data_o  <= sat_cmd(bus.pid_u_data);
            state         <= ST_FORWARD;
          end else if (tmo_cnt == '0) begin
            timeout_err   <= (err_clr ? '0 : timeout_err) | chan_mask;
            bus.u_valid_o <= 1'b1;
            bus.u_chn_o   <= chan;
            bus.u_data_o  <= '0;
            state         <= ST_FORWARD;
          end else begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
          end
        end

        ST_FORWARD: begin
          if (chan == LAST_CHN) begin
            state <= ST_WAIT_TICK;
          end else begin
            chan  <= chan + CHN_WIDTH'(1);
            state <= ST_SELECT;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_channel_scheduler.sv
// Directed bench: a full-rate instance for frame/clamp/stop/timeout checks and a 20-cycle-period
// instance for overrun and mid-frame reset; forwarded samples are checked against a scoreboard.
module tb_pid_channel_scheduler;

  localparam int DIV_MAIN = 26999;
  localparam int DIV_F    = 19;
  localparam int TMO      = 255;
  localparam int LAT_MAIN = 3;
  localparam int LAT_F    = 10;

  typedef struct packed {
    logic [2:0]         chn;
    logic signed [15:0] data;
  } exp_t;

  logic       clk;
  logic       rst, rst_f;
  logic       enable, enable_f;
  logic [3:0] stop_req, stop_req_f;
  logic       err_clr, err_clr_f;
  logic [3:0] stop, stop_f, timeout_err, tmo_f;
  logic       overrun, ovr_f;

  pid_channel_scheduler_if #(.CHN_WIDTH(3), .DATA_WIDTH(16)) bus ();
  pid_channel_scheduler_if #(.CHN_WIDTH(3), .DATA_WIDTH(16)) bus_f ();

  pid_channel_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .stop_req    (stop_req),
    .err_clr     (err_clr),
    .bus         (bus),
    .stop        (stop),
    .timeout_err (timeout_err),
    .overrun     (overrun)
  );

  pid_channel_scheduler #(
    .CLK_FREQ    (20),
    .SAMPLE_FREQ (1)
  ) dut_f (
    .clk         (clk),
    .rst         (rst_f),
    .enable      (enable_f),
    .stop_req    (stop_req_f),
    .err_clr     (err_clr_f),
    .bus         (bus_f),
    .stop        (stop_f),
    .timeout_err (tmo_f),
    .overrun     (ovr_f)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  exp_t q_main[$];
  exp_t q_fast[$];
  int   ch0_t[$];

  logic signed [15:0] resp_data [0:7];
  logic               resp_ans  [0:7];
  logic signed [15:0] resp_f    [0:7];
  int start_cnt [0:7];
  int start_cyc [0:7];
  int valid_cyc [0:7];
  int first_start   = -1;
  int first_start_f = -1;
  int n_main = 0;
  int n_fast = 0;
  int exp_chn_f = 0;
  bit drop_f = 1'b0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [15:0] ref_clamp(input logic signed [15:0] v);
    if (v > 16'sd1024) return 16'sd1024;
    if (v < -16'sd1024) return -16'sd1024;
    return v;
  endfunction

  function automatic exp_t mk(input int c, input int d);
    exp_t e;
    e.chn  = 3'(c);
    e.data = 16'(d);
    return e;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Full-rate engine model: answers LAT_MAIN cycles after start for channels enabled in resp_ans.
  initial begin
    int lat;
    logic [2:0] ch;
    lat = 0;
    ch = '0;
    bus.pid_done = 1'b0;
    bus.pid_u_data = '0;
    forever begin
      @(negedge clk);
      bus.pid_done = 1'b0;
      if (bus.pid_start) begin
        ch = bus.pid_chn;
        start_cnt[ch]++;
        start_cyc[ch] = cyc;
        if (first_start < 0) first_start = cyc;
        lat = LAT_MAIN;
      end else if (lat > 0) begin
        lat--;
        if (lat == 0 && resp_ans[ch]) begin
          bus.pid_done = 1'b1;
          bus.pid_u_data = resp_data[ch];
        end
      end
    end
  end

  // Fast engine model: always answers after LAT_F cycles and pushes the expected clamped sample.
  initial begin
    int lat;
    logic [2:0] ch;
    lat = 0;
    ch = '0;
    bus_f.pid_done = 1'b0;
    bus_f.pid_u_data = '0;
    forever begin
      @(negedge clk);
      bus_f.pid_done = 1'b0;
      if (bus_f.pid_start) begin
        ch = bus_f.pid_chn;
        if (first_start_f < 0) first_start_f = cyc;
        lat = LAT_F;
      end else if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          bus_f.pid_done = 1'b1;
          bus_f.pid_u_data = resp_f[ch];
          if (!drop_f) q_fast.push_back(mk(int'(ch), int'(ref_clamp(resp_f[ch]))));
        end
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (bus.u_valid_o) begin
      n_main++;
      valid_cyc[bus.u_chn_o] = cyc;
      if (bus.u_chn_o == 3'd0) ch0_t.push_back(cyc);
      if (q_main.size() == 0) begin
        check("main_unexpected_valid", 32'(bus.u_valid_o), 0);
      end else begin
        e = q_main.pop_front();
        check("main_chn", 32'(bus.u_chn_o), 32'(e.chn));
        check("main_data", bus.u_data_o, e.data);
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (bus_f.u_valid_o) begin
      n_fast++;
      check("fast_chn_order", 32'(bus_f.u_chn_o), exp_chn_f);
      exp_chn_f = (exp_chn_f + 1) % 4;
      if (q_fast.size() == 0) begin
        check("fast_unexpected_valid", 32'(bus_f.u_valid_o), 0);
      end else begin
        e = q_fast.pop_front();
        check("fast_chn", 32'(bus_f.u_chn_o), 32'(e.chn));
        check("fast_data", bus_f.u_data_o, e.data);
      end
    end
  end

  task automatic wait_main(input string tag, input int target, input int budget);
    for (int k = 0; k < budget && n_main < target; k++) @(negedge clk);
    check(tag, n_main, target);
  endtask

  task automatic wait_fast(input string tag, input int target, input int budget);
    for (int k = 0; k < budget && n_fast < target; k++) @(negedge clk);
    check(tag, n_fast, target);
  endtask

  initial begin
    int en_cyc, rel_cyc, n_hold;
    rst = 1'b1; rst_f = 1'b1;
    enable = 1'b0; enable_f = 1'b0;
    stop_req = '0; stop_req_f = '0;
    err_clr = 1'b0; err_clr_f = 1'b0;
    for (int i = 0; i < 8; i++) begin
      resp_data[i] = '0; resp_ans[i] = 1'b1; start_cnt[i] = 0;
      start_cyc[i] = 0; valid_cyc[i] = 0;
    end
    resp_f[0] = 16'sd1500; resp_f[1] = -16'sd77; resp_f[2] = 16'sd900; resp_f[3] = -16'sd20000;
    for (int i = 4; i < 8; i++) resp_f[i] = '0;
    repeat (3) @(negedge clk);

    check("rst_pid_start", 32'(bus.pid_start), 0);
    check("rst_pid_chn", 32'(bus.pid_chn), 0);
    check("rst_u_valid", 32'(bus.u_valid_o), 0);
    check("rst_u_chn", 32'(bus.u_chn_o), 0);
    check("rst_u_data", bus.u_data_o, 0);
    check("rst_stop", 32'(stop), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    @(negedge clk);

    // Frame 1: plain data, engine latency 3.
    resp_data[0] = 16'sd100; resp_data[1] = -16'sd200;
    resp_data[2] = 16'sd300; resp_data[3] = -16'sd400;
    q_main.push_back(mk(0, 100));  q_main.push_back(mk(1, -200));
    q_main.push_back(mk(2, 300));  q_main.push_back(mk(3, -400));
    enable = 1'b1;
    en_cyc = cyc;
    wait_main("frame1_count", 4, DIV_MAIN + 200);
    check("first_start_delay", first_start - en_cyc, DIV_MAIN + 3);
    for (int c = 0; c < 4; c++) check("done_to_valid", valid_cyc[c] - start_cyc[c], LAT_MAIN + 1);
    check("frame1_overrun", 32'(overrun), 0);

    // Frame 2: clamp high on ch0, timeout on ch1, ch2 stopped, clamp low on ch3.
    resp_data[0] = 16'sd2000; resp_ans[1] = 1'b0; resp_data[3] = -16'sd32768;
    for (int i = 0; i < 8; i++) start_cnt[i] = 0;
    q_main.push_back(mk(0, 1024)); q_main.push_back(mk(1, 0));
    q_main.push_back(mk(2, 0));    q_main.push_back(mk(3, -1024));
    stop_req = 4'b0100;
    @(negedge clk);
    check("stop_one_cycle", 32'(stop), 32'h4);
    wait_main("frame2_first", 5, DIV_MAIN + 200);
    enable = 1'b0;
    wait_main("frame2_count", 8, 1000);
    check("frame_period", (ch0_t.size() >= 2) ? ch0_t[1] - ch0_t[0] : -1, DIV_MAIN + 1);
    check("timeout_latency", valid_cyc[1] - start_cyc[1], TMO + 2);
    check("stopped_no_start", start_cnt[2], 0);
    check("timeout_err_set", 32'(timeout_err), 32'h2);
    check("stop_with_timeout", 32'(stop), 32'h6);
    check("frame2_overrun", 32'(overrun), 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr_timeout", 32'(timeout_err), 0);
    check("err_clr_stop", 32'(stop), 32'h4);
    stop_req = '0;
    @(negedge clk);
    check("stop_released", 32'(stop), 0);
    repeat (DIV_MAIN + 100) @(negedge clk);
    check("disabled_no_frame", n_main, 8);

    // Fast instance: 20-cycle period against ~52-cycle frames.
    check("fast_rst_overrun", 32'(ovr_f), 0);
    rst_f = 1'b0;
    @(negedge clk);
    enable_f = 1'b1;
    wait_fast("fast_frames", 12, 1500);
    check("fast_overrun", 32'(ovr_f), 1);

    // Reset during WAIT_DONE, then let the stale pid_done arrive after release.
    for (int k = 0; k < 200 && !bus_f.pid_start; k++) @(negedge clk);
    check("fast_saw_start", 32'(bus_f.pid_start), 1);
    repeat (3) @(negedge clk);
    drop_f = 1'b1;
    rst_f = 1'b1;
    #1;
    check("mid_rst_pid_start", 32'(bus_f.pid_start), 0);
    check("mid_rst_pid_chn", 32'(bus_f.pid_chn), 0);
    check("mid_rst_u_valid", 32'(bus_f.u_valid_o), 0);
    check("mid_rst_u_chn", 32'(bus_f.u_chn_o), 0);
    check("mid_rst_u_data", bus_f.u_data_o, 0);
    check("mid_rst_overrun", 32'(ovr_f), 0);
    check("mid_rst_stop", 32'(stop_f), 0);
    exp_chn_f = 0;
    n_hold = n_fast;
    first_start_f = -1;
    repeat (2) @(negedge clk);
    rst_f = 1'b0;
    rel_cyc = cyc;
    repeat (12) @(negedge clk);
    check("late_done_ignored", n_fast, n_hold);
    drop_f = 1'b0;
    for (int k = 0; k < 100 && first_start_f < 0; k++) @(negedge clk);
    check("restart_delay", first_start_f - rel_cyc, DIV_F + 3);
    enable_f = 1'b0;
    wait_fast("fast_last_frame", n_hold + 4, 300);
    repeat (60) @(negedge clk);
    check("fast_disabled_idle", n_fast, n_hold + 4);
    check("fast_scoreboard_empty", q_fast.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
